// File: rtl/board_input_conditioner_pkg.sv
// Shared IO-map constants for the board input path (also used by the data
// memory IO decode) and the debounce FSM state encoding.
package board_input_conditioner_pkg;

  localparam int KEY_WIDTH      = 4;
  localparam int SW_WIDTH       = 10;
  localparam int KEY_LSB        = 10;
  localparam int IO_INPUT_WIDTH = 14;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_SETTLING = 1'b1
  } db_state_e;

endpackage

// File: rtl/board_input_conditioner_debounce_bit.sv
// debounce_bit: single-bit conditioner.
//   Synchroniser chain -> 2-state debounce FSM with stability counter ->
//   registered edge detect on the debounced level.
// Ports:
//   clock, reset  core clock, async active-high reset
//   din           raw bit, already polarity-corrected (1 = active)
//   db            debounced level
//   rise, fall    one-cycle pulses, the cycle after db goes 0->1 / 1->0
module debounce_bit
  import board_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // With a one-cycle window the flip happens straight out of STABLE.
  localparam bit            SINGLE   = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  db_state_e              state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   db_n;
  logic                   db_q;

  // Plain shift chain; nothing between stages so every stage can resolve.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_ff <= '0;
    else       sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
  end

  assign sync = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DB_STABLE;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      db    <= db_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    db_n    = db;
    case (state)
      DB_STABLE: begin
        if (sync != db) begin
          if (SINGLE) begin
            db_n = ~db;
          end else begin
            state_n = DB_SETTLING;
            cnt_n   = CNT_ONE;
          end
        end
      end
      DB_SETTLING: begin
        if (sync == db) begin
          // Bounce: input went back before the window closed.
          state_n = DB_STABLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          db_n    = ~db;
          state_n = DB_STABLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = DB_STABLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Edge detect compares db against its one-cycle-old copy, so the pulse
  // lands the cycle after db flips and a flip can only give one pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_q <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      db_q <= db;
      rise <= db & ~db_q;
      fall <= ~db & db_q;
    end
  end

endmodule

// File: rtl/board_input_conditioner.sv
// board_input_conditioner: cleans the DE10-Lite push-buttons and slide
// switches into glitch-free levels for the core's io_input_bus.
// Ports:
//   clock, reset   core clock, async active-high reset
//   key_raw[3:0]   raw push-button pins (asynchronous)
//   sw_raw[9:0]    raw slide-switch pins (asynchronous)
//   io_input_bus   {key_db[3:0], sw_db[9:0]}, keys active-high
//   key_press      one-cycle pulse per debounced key 0->1
//   key_release    one-cycle pulse per debounced key 1->0
module board_input_conditioner
  import board_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  key_raw,
  input  logic [9:0]  sw_raw,
  output logic [13:0] io_input_bus,
  output logic [3:0]  key_press,
  output logic [3:0]  key_release
);

  logic [KEY_WIDTH-1:0]      key_in;
  logic [IO_INPUT_WIDTH-1:0] bits_in;
  logic [IO_INPUT_WIDTH-1:0] db;
  logic [IO_INPUT_WIDTH-1:0] rise;
  logic [IO_INPUT_WIDTH-1:0] fall;
  logic                      sw_edges_unused;

  // Inversion sits ahead of the synchroniser so every chain resets to 0
  // and 0 means "released" for the keys.
  assign key_in  = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;
  assign bits_in = {key_in, sw_raw};

  for (genvar gi = 0; gi < IO_INPUT_WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .din   (bits_in[gi]),
      .db    (db[gi]),
      .rise  (rise[gi]),
      .fall  (fall[gi])
    );
  end

  assign io_input_bus = db;
  assign key_press    = rise[KEY_LSB +: KEY_WIDTH];
  assign key_release  = fall[KEY_LSB +: KEY_WIDTH];

  // Switches have no pulse outputs; their edge flops are left for synthesis to trim.
  assign sw_edges_unused = ^{rise[SW_WIDTH-1:0], fall[SW_WIDTH-1:0]};

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench: the stimulus thread pushes the hand-derived expected
// outputs for each cycle; a negedge monitor pops and compares.
module tb_board_input_conditioner;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  key_raw;
  logic [9:0]  sw_raw;
  logic [13:0] io_input_bus;
  logic [3:0]  key_press;
  logic [3:0]  key_release;

  typedef struct packed {
    logic [13:0] bus;
    logic [3:0]  press;
    logic [3:0]  rel;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  board_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .KEY_ACTIVE_LOW  (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key_raw      (key_raw),
    .sw_raw       (sw_raw),
    .io_input_bus (io_input_bus),
    .key_press    (key_press),
    .key_release  (key_release)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
  endtask

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("io_input_bus", 32'(io_input_bus), 32'(e.bus));
      check("key_press", 32'(key_press), 32'(e.press));
      check("key_release", 32'(key_release), 32'(e.rel));
      check("press_and_release", 32'(key_press & key_release), 32'd0);
    end
  end

  // One clock; the expectation pushed describes outputs after this edge.
  task automatic step();
    @(posedge clock);
    #1;
    q.push_back(cur);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset   = 1'b1;
    key_raw = 4'hF;
    sw_raw  = 10'h3FF;
    cur     = '0;

    // Reset with all switches up and keys released
    steps(3);
    reset = 1'b0;
    steps(5);
    cur.bus[9:0] = 10'h3FF;
    step();
    steps(3);

    // Clean press of key 0
    key_raw[0] = 1'b0;
    steps(5);
    cur.bus[10] = 1'b1;
    step();
    cur.press = 4'b0001;
    step();
    cur.press = 4'b0000;
    steps(3);

    // All switches down
    sw_raw = 10'h000;
    steps(5);
    cur.bus[9:0] = 10'h000;
    step();
    steps(2);

    // Bouncy switch 3: 1,0,1,0 every two clocks, then held 1
    sw_raw[3] = 1'b1; steps(2);
    sw_raw[3] = 1'b0; steps(2);
    sw_raw[3] = 1'b1; steps(2);
    sw_raw[3] = 1'b0; steps(2);
    sw_raw[3] = 1'b1;
    steps(5);
    cur.bus[3] = 1'b1;
    step();
    steps(3);

    // Three-cycle glitch on switch 9 is rejected
    sw_raw[9] = 1'b1;
    steps(3);
    sw_raw[9] = 1'b0;
    steps(10);

    // Release key 0
    key_raw[0] = 1'b1;
    steps(5);
    cur.bus[10] = 1'b0;
    step();
    cur.rel = 4'b0001;
    step();
    cur.rel = 4'b0000;
    steps(3);

    // All 14 inputs change on the same edge
    key_raw = 4'h0;
    sw_raw  = 10'h3F7;
    steps(5);
    cur.bus = 14'h3FF7;
    step();
    cur.press = 4'hF;
    step();
    cur.press = 4'h0;
    steps(3);

    key_raw = 4'hF;
    sw_raw  = 10'h008;
    steps(5);
    cur.bus = 14'h0008;
    step();
    cur.rel = 4'hF;
    step();
    cur.rel = 4'h0;
    steps(3);

    // Reset lands while key 2 is part-way through settling
    key_raw[2] = 1'b0;
    steps(3);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cur   = '0;
    q.push_back(cur);
    steps(2);
    reset = 1'b0;
    steps(5);
    cur.bus = 14'h1008;
    step();
    cur.press = 4'b0100;
    step();
    cur.press = 4'b0000;
    steps(3);

    @(negedge clock);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
